jelly_texture_cache_miss_arbiter: RTL and testbench

Merges the miss-fill request ports (AR/R) of CACHE_NUM texture L1 cache units onto one downstream port toward the L2 cache or the memory reader. Requests are granted round-robin. Each granted cache index is queued in an ID FIFO, and in-order read bursts are routed back to the requesting L1 until `m_rlast`. It sits between the L1 cache array's `m_ar*`/`m_r*` buses and the single shared fill port.

---
 rtl/jelly_texture_cache_miss_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_jelly_texture_cache_miss_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_texture_cache_miss_arbiter.sv
// Purpose : merge CACHE_NUM texture L1 miss-fill AR/R ports onto one shared fill port.
// Latency : AR is combinational (1 cycle with JELLY_TEXTURE_CACHE_MISS_ARBITER_AR_REG_EN); R is always combinational.
// Backpres: AR stalls when the ID FIFO is full or m_arready is low; R stalls on the head port's s_rready or an empty FIFO.
//
// Ports:
//   reset, clk               synchronous active-high reset, single rising-edge clock
//   s_araddrx/y, s_arvalid   per-L1 request (packed slices, port i at [i*W +: W]); s_arready one-hot grant
//   s_rdata/s_rlast/s_rvalid per-L1 fill beats (data broadcast); s_rready per-L1 accept
//   m_ar*                    merged request toward L2 / memory reader; m_arid = granted L1 index
//   m_r*                     in-order fill beats, bursts delimited only by m_rlast
// Optional macro: JELLY_TEXTURE_CACHE_MISS_ARBITER_AR_REG_EN registers the AR output (one-entry stage).
module jelly_texture_cache_miss_arbiter #(
    parameter int CACHE_NUM         = 4,
    parameter int ADDR_X_WIDTH      = 12,
    parameter int ADDR_Y_WIDTH      = 12,
    parameter int DATA_WIDTH        = 48,
    parameter int ID_FIFO_PTR_WIDTH = 2,
    parameter int ID_WIDTH          = (CACHE_NUM <= 1) ? 1 : $clog2(CACHE_NUM)
) (
    input  logic                               reset,
    input  logic                               clk,

    input  logic [CACHE_NUM*ADDR_X_WIDTH-1:0]  s_araddrx,
    input  logic [CACHE_NUM*ADDR_Y_WIDTH-1:0]  s_araddry,
    input  logic [CACHE_NUM-1:0]               s_arvalid,
    output logic [CACHE_NUM-1:0]               s_arready,
    output logic [CACHE_NUM-1:0]               s_rlast,
    output logic [CACHE_NUM*DATA_WIDTH-1:0]    s_rdata,
    output logic [CACHE_NUM-1:0]               s_rvalid,
    input  logic [CACHE_NUM-1:0]               s_rready,

    output logic [ADDR_X_WIDTH-1:0]            m_araddrx,
    output logic [ADDR_Y_WIDTH-1:0]            m_araddry,
    output logic [ID_WIDTH-1:0]                m_arid,
    output logic                               m_arvalid,
    input  logic                               m_arready,
    input  logic                               m_rlast,
    input  logic [DATA_WIDTH-1:0]              m_rdata,
    input  logic                               m_rvalid,
    output logic                               m_rready
);

    localparam int FIFO_DEPTH = 1 << ID_FIFO_PTR_WIDTH;
    localparam int FIFO_AW    = (ID_FIFO_PTR_WIDTH == 0) ? 1 : ID_FIFO_PTR_WIDTH;
    localparam int PW         = ID_FIFO_PTR_WIDTH + 1;

    // Outputs stay quiet during reset and for one cycle after it.
    logic rst_dly;
    logic active;

    always_ff @(posedge clk) begin
        rst_dly <= reset;
    end
    assign active = !reset && !rst_dly;

    // ---------------- ID FIFO (pointers carry a wrap bit) ----------------
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [ID_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_addr, rd_addr;
    logic                 full, empty, push, pop;
    logic [ID_WIDTH-1:0]  head;
    logic [ID_WIDTH-1:0]  grant;

    assign full    = (wr_ptr ^ rd_ptr) == PW'(FIFO_DEPTH);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_addr = FIFO_AW'(wr_ptr & PW'(FIFO_DEPTH - 1));
    assign rd_addr = FIFO_AW'(rd_ptr & PW'(FIFO_DEPTH - 1));
    assign head    = fifo_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_addr] <= grant;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ---------------- Round-robin search ----------------
    logic [ID_WIDTH-1:0] rr;
    logic                srch_vld;
    logic [ID_WIDTH-1:0] srch_id;

    always_comb begin
        int idx;
        idx      = 0;
        srch_vld = 1'b0;
        srch_id  = '0;
        for (int i = 1; i <= CACHE_NUM; i++) begin
            idx = (int'(rr) + i) % CACHE_NUM;
            if (!srch_vld && s_arvalid[idx]) begin
                srch_vld = 1'b1;
                srch_id  = ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= ID_WIDTH'(CACHE_NUM - 1);
        end else if (push) begin
            rr <= grant;
        end
    end

    logic [ADDR_X_WIDTH-1:0] sel_x;
    logic [ADDR_Y_WIDTH-1:0] sel_y;
    logic [CACHE_NUM-1:0]    grant_oh;

    assign sel_x    = s_araddrx[int'(grant)*ADDR_X_WIDTH +: ADDR_X_WIDTH];
    assign sel_y    = s_araddry[int'(grant)*ADDR_Y_WIDTH +: ADDR_Y_WIDTH];
    assign grant_oh = CACHE_NUM'(1) << grant;

`ifdef JELLY_TEXTURE_CACHE_MISS_ARBITER_AR_REG_EN
    // One-entry output register; the FIFO push happens on load so the ID
    // order always matches the order requests leave this stage.
    logic                    ar_vld;
    logic [ADDR_X_WIDTH-1:0] ar_x;
    logic [ADDR_Y_WIDTH-1:0] ar_y;
    logic [ID_WIDTH-1:0]     ar_id;
    logic                    ar_load;

    assign grant   = srch_id;
    assign ar_load = !ar_vld || m_arready;
    assign push    = active && ar_load && !full && srch_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_vld <= 1'b0;
            ar_x   <= '0;
            ar_y   <= '0;
            ar_id  <= '0;
        end else if (ar_load) begin
            ar_vld <= push;
            ar_x   <= push ? sel_x : '0;
            ar_y   <= push ? sel_y : '0;
            ar_id  <= push ? grant : '0;
        end
    end

    assign m_arvalid = ar_vld;
    assign m_araddrx = ar_x;
    assign m_araddry = ar_y;
    assign m_arid    = ar_id;
    assign s_arready = push ? grant_oh : '0;
`else
    // A presented but unaccepted request keeps its grant even if a port
    // closer to the round-robin pointer raises s_arvalid meanwhile.
    logic                hold_vld;
    logic [ID_WIDTH-1:0] hold_id;

    assign grant     = hold_vld ? hold_id : srch_id;
    assign m_arvalid = active && (hold_vld || srch_vld) && !full;
    assign push      = m_arvalid && m_arready;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_id  <= '0;
        end else begin
            hold_vld <= m_arvalid && !m_arready;
            hold_id  <= grant;
        end
    end

    assign m_araddrx = m_arvalid ? sel_x : '0;
    assign m_araddry = m_arvalid ? sel_y : '0;
    assign m_arid    = m_arvalid ? grant : '0;
    assign s_arready = push ? grant_oh : '0;
`endif

    // ---------------- R routing to the FIFO head ----------------
    always_comb begin
        s_rvalid = '0;
        s_rlast  = '0;
        for (int k = 0; k < CACHE_NUM; k++) begin
            if (active && head == ID_WIDTH'(k)) begin
                s_rvalid[k] = m_rvalid && !empty;
                s_rlast[k]  = m_rlast;
            end
        end
    end

    assign s_rdata  = {CACHE_NUM{m_rdata}};
    assign m_rready = active && !empty && s_rready[head];
    assign pop      = m_rvalid && m_rready && m_rlast;

endmodule

// File: tb/tb_jelly_texture_cache_miss_arbiter.sv
`timescale 1ns/1ps
module tb_jelly_texture_cache_miss_arbiter;

    localparam int CN   = 4;
    localparam int AXW  = 12;
    localparam int AYW  = 12;
    localparam int DW   = 48;
    localparam int PTRW = 1;
    localparam int IDW  = 2;

    logic                reset, clk;
    logic [CN*AXW-1:0]   s_araddrx;
    logic [CN*AYW-1:0]   s_araddry;
    logic [CN-1:0]       s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [CN*DW-1:0]    s_rdata;
    logic [AXW-1:0]      m_araddrx;
    logic [AYW-1:0]      m_araddry;
    logic [IDW-1:0]      m_arid;
    logic                m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [DW-1:0]       m_rdata;

    jelly_texture_cache_miss_arbiter #(
        .CACHE_NUM(CN), .ADDR_X_WIDTH(AXW), .ADDR_Y_WIDTH(AYW),
        .DATA_WIDTH(DW), .ID_FIFO_PTR_WIDTH(PTRW)
    ) dut (
        .reset(reset), .clk(clk),
        .s_araddrx(s_araddrx), .s_araddry(s_araddry),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddrx(m_araddrx), .m_araddry(m_araddry), .m_arid(m_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Fixed per-port addresses; port 2 carries X=5, Y=7.
    function automatic int px(int k); return (k == 2) ? 5 : 16 + k; endfunction
    function automatic int py(int k); return (k == 2) ? 7 : 32 + k; endfunction

    always_comb begin
        s_araddrx = '0;
        s_araddry = '0;
        for (int k = 0; k < CN; k++) begin
            s_araddrx[k*AXW +: AXW] = AXW'(px(k));
            s_araddry[k*AYW +: AYW] = AYW'(py(k));
        end
    end

    typedef struct packed { logic [7:0] id; logic [AXW-1:0] x; logic [AYW-1:0] y; } ar_exp_t;
    typedef struct packed { logic [7:0] port; logic [DW-1:0] data; logic last; } r_exp_t;
    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];

    task automatic push_ar(input int id);
        ar_q.push_back('{8'(id), AXW'(px(id)), AYW'(py(id))});
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Monitor: every handshake on either side pops and checks one expectation.
    always @(negedge clk) begin
        ar_exp_t ae;
        r_exp_t  re;
        if (m_arvalid && m_arready) begin
            if (ar_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ar_unexpected actual id=%0d required=no request", m_arid);
            end else begin
                ae = ar_q.pop_front();
                check("ar_id", 64'(m_arid), 64'(ae.id));
                check("ar_x", 64'(m_araddrx), 64'(ae.x));
                check("ar_y", 64'(m_araddry), 64'(ae.y));
                check("ar_onehot", 64'(s_arready), 64'(1) << ae.id);
            end
        end
        if (m_rvalid && m_rready) begin
            if (r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected actual s_rvalid=0x%0h required=no beat", s_rvalid);
            end else begin
                re = r_q.pop_front();
                check("r_valid", 64'(s_rvalid), 64'(1) << re.port);
                check("r_data", 64'(s_rdata[int'(re.port)*DW +: DW]), 64'(re.data));
                check("r_last", 64'(s_rlast), 64'(re.last) << re.port);
            end
        end
    end

    task automatic drive_burst(input int port, input int n, input logic [DW-1:0] d0);
        logic got;
        for (int b = 0; b < n; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = d0 + DW'(b);
            m_rlast  = (b == n - 1);
            r_q.push_back('{8'(port), d0 + DW'(b), (b == n - 1)});
            @(negedge clk);
            check("r_no_bubble", 64'(m_rready), 64'd1);
            got = m_rready;
            for (int t = 0; t < 20 && !got; t++) begin
                step();
                @(negedge clk);
                got = m_rready;
            end
            if (!got) begin
                checks++; failures++;
                $display("FAIL r_timeout actual m_rready=0 required=1 port=%0d", port);
            end
            check("r_route", 64'(s_rvalid), 64'(1) << port);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int nbeat;

    initial begin
        reset = 1'b1; s_arvalid = '0; s_rready = '1; m_arready = 1'b0;
        m_rlast = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        repeat (3) step();

        // Reset state, with R beats offered to expose any ungated output.
        m_rvalid = 1'b1; m_rlast = 1'b1;
        @(negedge clk);
        check("rst_arvalid", 64'(m_arvalid), 0);
        check("rst_arready", 64'(s_arready), 0);
        check("rst_rready", 64'(m_rready), 0);
        check("rst_rvalid", 64'(s_rvalid), 0);
        check("rst_rlast", 64'(s_rlast), 0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("post_rst_rlast", 64'(s_rlast), 0);
        check("post_rst_rready", 64'(m_rready), 0);
        check("post_rst_arid", 64'(m_arid), 0);
        check("post_rst_addr", 64'({m_araddrx, m_araddry}), 0);
        step(); m_rvalid = 1'b0; m_rlast = 1'b0;

        // Single request on port 2, held while m_arready is low.
        s_arvalid = 4'b0100;
        @(negedge clk);
        check("a_arvalid", 64'(m_arvalid), 1);
        check("a_x", 64'(m_araddrx), 5);
        check("a_y", 64'(m_araddry), 7);
        check("a_id", 64'(m_arid), 2);
        check("a_no_ready", 64'(s_arready), 0);
        step();
        @(negedge clk);
        check("a_hold_id", 64'(m_arid), 2);
        step(); push_ar(2); m_arready = 1'b1;
        @(negedge clk);
        check("a_accept", 64'(s_arready), 64'h4);
        step(); s_arvalid = '0;
        drive_burst(2, 1, 48'h55);
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Reset in the middle of a burst to port 1.
        push_ar(1); s_arvalid = 4'b0010;
        step(); s_arvalid = '0;
        r_q.push_back('{8'd1, 48'h66, 1'b0});
        m_rvalid = 1'b1; m_rdata = 48'h66; m_rlast = 1'b0;
        @(negedge clk);
        check("b_beat_rready", 64'(m_rready), 1);
        step(); reset = 1'b1; m_rdata = 48'h67;
        @(negedge clk);
        check("b_rst_rready", 64'(m_rready), 0);
        check("b_rst_rvalid", 64'(s_rvalid), 0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("b_win_rready", 64'(m_rready), 0);
        step();

        // Round robin from reset pointer, 1-beat bursts draining concurrently.
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 48'h100;
        s_arvalid = 4'b1111; m_arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_ar(i % 4);
            r_q.push_back('{8'(i % 4), 48'h100 + 48'(i), 1'b1});
        end
        nbeat = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_order", 64'(m_arid), 64'(c % 4));
            check("rr_onehot", 64'(s_arready), 64'(1) << (c % 4));
            if (c == 0) check("rr_stall_empty", 64'(m_rready), 0);
            if (m_rvalid && m_rready) nbeat++;
            step();
            m_rdata = 48'h100 + 48'(nbeat);
        end
        s_arvalid = '0;
        for (int t = 0; t < 10 && nbeat < 5; t++) begin
            @(negedge clk);
            if (m_rready) nbeat++;
            step();
            m_rdata = 48'h100 + 48'(nbeat);
        end
        check("rr_beats", 64'(nbeat), 5);
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Fill the 2-deep ID FIFO, then check that it blocks further requests.
        push_ar(1); push_ar(3); s_arvalid = 4'b1010;
        @(negedge clk);
        check("full_first", 64'(s_arready), 64'h2);
        step();
        @(negedge clk);
        check("full_second", 64'(s_arready), 64'h8);
        step(); s_arvalid = 4'b0001;
        repeat (2) begin
            @(negedge clk);
            check("full_block_rdy", 64'(s_arready), 0);
            check("full_block_vld", 64'(m_arvalid), 0);
            step();
        end
        // Popping on the last beat must not admit a request in that same cycle.
        drive_burst(1, 4, 48'h200);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        push_ar(0);
        @(negedge clk);
        check("after_pop", 64'(s_arready), 64'h1);
        step(); s_arvalid = '0;

        // Two bursts back to back to different heads.
        drive_burst(3, 2, 48'h300);
        drive_burst(0, 2, 48'h310);
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Head port stalls for 3 cycles, then completes.
        push_ar(0); s_arvalid = 4'b0001;
        step(); s_arvalid = '0;
        s_rready = 4'b1110; m_rvalid = 1'b1; m_rdata = 48'h400; m_rlast = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_rready", 64'(m_rready), 0);
            check("stall_rvalid", 64'(s_rvalid), 64'h1);
            check("stall_data", 64'(s_rdata[0 +: DW]), 64'h400);
            step();
        end
        s_rready = '1;
        drive_burst(0, 3, 48'h400);
        m_rvalid = 1'b0; m_rlast = 1'b0;

        repeat (3) step();
        @(negedge clk);
        check("end_ar_q", 64'(ar_q.size()), 0);
        check("end_r_q", 64'(r_q.size()), 0);
        m_rvalid = 1'b1;
        #1;
        check("end_empty_rready", 64'(m_rready), 0);
        m_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
